// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and default link parameters,
// kept here so the matching receiver can reuse them.
package uart_pkg;

    localparam int UART_DATA_WIDTH   = 8;
    localparam int UART_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } tx_state_e;

    // Index width that stays legal for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Modulo-CLKS_PER_BIT cycle counter with synchronous clear and a flag marking
// the final cycle of each serial bit period.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic last
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit.
// Line outputs are registered, so they trail the FSM state by one cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    input  logic                  i_Tx_DV,
    input  logic [DATA_WIDTH-1:0] i_Tx_Data,
    output logic                  o_Tx_Active,
    output logic                  o_Tx_Serial,
    output logic                  o_Tx_Done
);

    localparam int            IW       = idx_width(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [IW-1:0]         bit_idx_q;
    logic [IW-1:0]         bit_idx_d;

    logic serial_q;
    logic serial_d;
    logic active_q;
    logic active_d;
    logic done_q;
    logic done_d;

    logic baud_clr;
    logic baud_last;

    // Bit timing restarts from zero whenever no frame is being sent.
    assign baud_clr = (state_q == IDLE) || (state_q == CLEANUP);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk  (i_Clock),
        .rst_n(i_Rst_n),
        .clr  (baud_clr),
        .last (baud_last)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bit_idx_d = bit_idx_q;
        unique case (state_q)
            IDLE: begin
                if (i_Tx_DV) begin
                    data_d  = i_Tx_Data;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_d = CLEANUP;
                end
            end
            CLEANUP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Done is raised from the final STOP cycle so it lands on the last
    // registered stop-bit cycle of the line.
    always_comb begin
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            START: begin
                serial_d = 1'b0;
                active_d = 1'b1;
            end
            DATA: begin
                serial_d = data_q[bit_idx_q];
                active_d = 1'b1;
            end
            STOP: begin
                active_d = 1'b1;
                done_d   = baud_last;
            end
            default: begin
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (8 bits / 87 clocks, 5 bits / 4 clocks) checked
// every cycle against a frame-arithmetic line model, plus directed scenarios.
module tb_uart_tx;

    localparam int DW0  = 8;
    localparam int CPB0 = 87;
    localparam int DW1  = 5;
    localparam int CPB1 = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv  [2];
    logic [15:0] din [2];

    logic act0, ser0, done0;
    logic act1, ser1, done1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: edge at which the frame in flight was accepted, first edge
    // at which a new request can be taken, and the captured word.
    int          t_acc     [2];
    int          next_ok   [2];
    logic [15:0] cap       [2];
    int          last_done [2];

    always #50 clk = ~clk;

    uart_tx #(
        .DATA_WIDTH  (DW0),
        .CLKS_PER_BIT(CPB0)
    ) dut0 (
        .i_Clock    (clk),
        .i_Rst_n    (rst_n),
        .i_Tx_DV    (dv[0]),
        .i_Tx_Data  (din[0][DW0-1:0]),
        .o_Tx_Active(act0),
        .o_Tx_Serial(ser0),
        .o_Tx_Done  (done0)
    );

    uart_tx #(
        .DATA_WIDTH  (DW1),
        .CLKS_PER_BIT(CPB1)
    ) dut1 (
        .i_Clock    (clk),
        .i_Rst_n    (rst_n),
        .i_Tx_DV    (dv[1]),
        .i_Tx_Data  (din[1][DW1-1:0]),
        .o_Tx_Active(act1),
        .o_Tx_Serial(ser1),
        .o_Tx_Done  (done1)
    );

    function automatic int dwid(input int id);
        return (id == 0) ? DW0 : DW1;
    endfunction

    function automatic int cpbv(input int id);
        return (id == 0) ? CPB0 : CPB1;
    endfunction

    // {serial, active, done}
    function automatic logic [2:0] obs(input int id);
        return (id == 0) ? {ser0, act0, done0} : {ser1, act1, done1};
    endfunction

    // Expected line after edge e: frame cycle k selects bit k/cpb of {start, data, stop}.
    function automatic logic [2:0] model_out(input int id, input int e);
        int   n;
        int   k;
        int   bi;
        logic s;
        n = (dwid(id) + 2) * cpbv(id);
        k = e - t_acc[id] - 1;
        if (k < 0 || k >= n) return 3'b100;
        bi = k / cpbv(id);
        if (bi == 0)                s = 1'b0;
        else if (bi == dwid(id) + 1) s = 1'b1;
        else                        s = cap[id][bi-1];
        return {s, 1'b1, (k == n - 1)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [2:0] o;
        @(posedge clk);
        cyc++;
        for (int id = 0; id < 2; id++) begin
            if (!rst_n) begin
                t_acc[id]   = -100000;
                next_ok[id] = 0;
            end else if (dv[id] && cyc >= next_ok[id]) begin
                t_acc[id]   = cyc;
                cap[id]     = din[id] & ((16'd1 << dwid(id)) - 16'd1);
                next_ok[id] = cyc + (dwid(id) + 2) * cpbv(id) + 2;
                $display("TX dut%0d cyc=%0d data=0x%0h", id, cyc, cap[id]);
            end
        end
        #1;
        for (int id = 0; id < 2; id++) begin
            o = obs(id);
            check($sformatf("wave_dut%0d_cyc%0d", id, cyc), 32'(o), 32'(model_out(id, cyc)));
            if (o[0]) last_done[id] = cyc;
        end
    endtask

    // Mid-bit sampler; optionally rewrites the input word while the frame is in flight.
    task automatic rx_word(input int id, input logic chg, input logic [15:0] chg_val,
                           output logic [15:0] word, output logic [1:0] frm, output int start_cyc);
        int         guard;
        int         dw;
        int         cpb;
        int         target;
        logic [2:0] o;
        dw        = dwid(id);
        cpb       = cpbv(id);
        word      = '0;
        frm       = 2'b00;
        start_cyc = cyc;
        guard     = 0;
        o         = obs(id);
        while (o[2] !== 1'b0 && guard < 2000) begin
            tick();
            guard++;
            o = obs(id);
        end
        if (o[2] !== 1'b0) begin
            check($sformatf("rx_dut%0d_start_seen", id), {31'd0, o[2]}, 32'd0);
            return;
        end
        start_cyc = cyc;
        for (int j = 0; j <= dw + 1; j++) begin
            target = j * cpb + cpb / 2;
            while (cyc - start_cyc < target) tick();
            o = obs(id);
            if (j == 0)           frm[0]      = o[2];
            else if (j == dw + 1) frm[1]      = o[2];
            else                  word[j-1]   = o[2];
            if (chg && j == 4) din[id] = chg_val;
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [1:0]  f;
        int          sc;
        int          sc2;
        int          low;
        int          hi;
        int          act;
        int          dn;
        int          dpos;
        logic [2:0]  o;
        logic [27:0] vec;
        logic [27:0] exp_vec;
        logic [6:0]  bits13;

        for (int id = 0; id < 2; id++) begin
            dv[id]        = 1'b0;
            din[id]       = 16'd0;
            t_acc[id]     = -100000;
            next_ok[id]   = 0;
            cap[id]       = 16'd0;
            last_done[id] = 0;
        end

        // Power-on reset held for 5 cycles.
        repeat (5) tick();
        rst_n = 1'b1;
        tick();
        check("rst_serial0", 32'(ser0), 32'd1);
        check("rst_active0", 32'(act0), 32'd0);
        check("rst_done0",   32'(done0), 32'd0);
        check("rst_serial1", 32'(ser1), 32'd1);
        check("rst_active1", 32'(act1), 32'd0);
        check("rst_done1",   32'(done1), 32'd0);

        // Narrow instance: 0x13 over 5 bits, 4 clocks per bit.
        dv[1] = 1'b1; din[1] = 16'h13;
        tick();
        dv[1] = 1'b0;
        vec = '0; act = 0; dn = 0; dpos = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            o = obs(1);
            if (o[1]) begin
                if (act < 28) vec[act] = o[2];
                act++;
            end
            if (o[0]) begin dn++; dpos = act; end
        end
        bits13 = 7'b1100110;
        for (int k = 0; k < 28; k++) exp_vec[k] = bits13[k/4];
        check("p13_wave",     32'(vec), 32'(exp_vec));
        check("p13_active",   act,  28);
        check("p13_done_cnt", dn,   1);
        check("p13_done_pos", dpos, 28);

        // Single 0x00 frame: low span, stop span, active length, done placement.
        dv[0] = 1'b1; din[0] = 16'h00;
        tick();
        dv[0] = 1'b0;
        low = 0; hi = 0; act = 0; dn = 0; dpos = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            o = obs(0);
            if (o[1]) begin
                act++;
                if (o[2]) hi++; else low++;
            end
            if (o[0]) begin dn++; dpos = act; end
        end
        check("f00_low",      low,  783);
        check("f00_high",     hi,   87);
        check("f00_active",   act,  870);
        check("f00_done_cnt", dn,   1);
        check("f00_done_pos", dpos, 870);

        // 0xA5 decoded by mid-bit sampling.
        dv[0] = 1'b1; din[0] = 16'hA5;
        tick();
        dv[0] = 1'b0;
        rx_word(0, 1'b0, 16'h0, w, f, sc);
        check("a5_data",    32'(w), 32'h00A5);
        check("a5_framing", 32'(f), 32'h2);
        repeat (100) tick();

        // Continuous request, word changed mid-frame.
        dv[0] = 1'b1; din[0] = 16'h99;
        rx_word(0, 1'b1, 16'hAA, w, f, sc);
        check("cont_first",    32'(w), 32'h0099);
        check("cont_first_fr", 32'(f), 32'h2);
        rx_word(0, 1'b0, 16'h0, w, f, sc2);
        dv[0] = 1'b0;
        check("cont_second",    32'(w), 32'h00AA);
        check("cont_second_fr", 32'(f), 32'h2);
        check("cont_gap",       sc2 - last_done[0] - 1, 2);
        repeat (100) tick();

        // Request arriving during the stop bit is dropped.
        dv[0] = 1'b1; din[0] = 16'h0F;
        tick();
        dv[0] = 1'b0;
        rx_word(0, 1'b0, 16'h0, w, f, sc);
        check("busy_data", 32'(w), 32'h000F);
        dv[0] = 1'b1; din[0] = 16'h55;
        tick();
        dv[0] = 1'b0;
        dn = 0; low = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            o = obs(0);
            if (o[0]) dn++;
            if (o[2] == 1'b0) low++;
        end
        check("busy_done_cnt", dn,  1);
        check("busy_no_frame", low, 0);

        // Reset in the middle of the data bits of a 0x00 frame.
        dv[0] = 1'b1; din[0] = 16'h00;
        tick();
        dv[0] = 1'b0;
        repeat (300) tick();
        #20;
        rst_n = 1'b0;
        #1;
        check("rstmid_serial", 32'(ser0), 32'd1);
        check("rstmid_active", 32'(act0), 32'd0);
        check("rstmid_done",   32'(done0), 32'd0);
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        dv[0] = 1'b1; din[0] = 16'h3C;
        tick();
        dv[0] = 1'b0;
        rx_word(0, 1'b0, 16'h0, w, f, sc);
        check("recover_data", 32'(w), 32'h003C);
        repeat (100) tick();

        // Random requests and data on both instances.
        for (int i = 0; i < 6000; i++) begin
            for (int id = 0; id < 2; id++) begin
                dv[id]  = ($urandom_range(0, 7) == 0);
                din[id] = 16'($urandom);
            end
            tick();
        end
        dv[0] = 1'b0;
        dv[1] = 1'b0;
        repeat (900) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, 8N1-style framing: one start bit, DATA_WIDTH data bits LSB first, one stop bit, no parity.
- Bit timing derives from the system clock divided by CLKS_PER_BIT (e.g. 10 MHz / 115200 baud = 87).
- Sits between a byte-producing client (valid-strobe interface) and the serial TX pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 87, clock cycles per serial bit (>= 2).

Ports:
- i_Clock  input  1  system clock, rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Tx_DV  input  1  data valid; requests transmission of i_Tx_Data.
- i_Tx_Data  input  DATA_WIDTH  word to transmit; captured when the request is accepted.
- o_Tx_Active  output  1  high while a frame (start through stop) is on the line.
- o_Tx_Serial  output  1  serial line; idles high.
- o_Tx_Done  output  1  one-cycle pulse at the end of each frame's stop bit.

Behaviour:
- Reset (i_Rst_n low, asynchronous):
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0.
  - State IDLE; counters and data shift register cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high without waiting for a clock.
- States: IDLE, START, DATA, STOP, CLEANUP.
- IDLE:
  - o_Tx_Serial=1, o_Tx_Active=0.
  - On a rising edge with i_Tx_DV=1: capture i_Tx_Data into an internal register, clear the clock counter, go to START.
- START:
  - o_Tx_Serial=0, o_Tx_Active=1, held CLKS_PER_BIT cycles.
  - Then go to DATA with bit index 0.
- DATA:
  - o_Tx_Serial = captured[bit_index], each bit held CLKS_PER_BIT cycles, LSB first.
  - After bit DATA_WIDTH-1, go to STOP.
- STOP:
  - o_Tx_Serial=1, held CLKS_PER_BIT cycles.
  - On the last cycle of the stop bit, assert o_Tx_Done for exactly one cycle.
  - Go to CLEANUP.
- CLEANUP:
  - One cycle, line high, o_Tx_Active=0, o_Tx_Done=0; go to IDLE.
- Latency: o_Tx_Serial falls on the first rising edge after the edge that samples i_Tx_DV=1 in IDLE. Outputs are registered.
- Frame length: (DATA_WIDTH+2)*CLKS_PER_BIT cycles of o_Tx_Active=1.
- i_Tx_DV held continuously high produces back-to-back frames separated by exactly 2 idle-high cycles (CLEANUP + IDLE sample).
- i_Tx_DV and i_Tx_Data are ignored outside IDLE. Changing i_Tx_Data mid-frame does not affect the frame in flight.
- Counter widths:
  - Clock counter: $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1, then wraps to 0 on the bit transition.
  - Bit index: $clog2(DATA_WIDTH) bits (minimum 1).
  - No other arithmetic.
- o_Tx_Serial never glitches low outside START or a 0 data bit.

Decomposition:
- Package uart_pkg:
  - State enum (IDLE, START, DATA, STOP, CLEANUP).
  - Default DATA_WIDTH and CLKS_PER_BIT constants, shared with the future uart_rx.
- Optional sub-module uart_baud_cnt: a CLKS_PER_BIT-modulo counter with clear input and last-cycle flag. Otherwise a single module.

Test Plan:
- Reset: hold i_Rst_n=0 for 5 cycles, then release -> o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0. Assert i_Rst_n=0 mid-DATA -> line high immediately; no o_Tx_Done.
- Single frame, 0x00, CLKS_PER_BIT=87, 10 MHz clock, i_Tx_DV pulsed one cycle:
  - Line low for 9*87=783 cycles, then high for 87 cycles.
  - o_Tx_Done pulses once, at cycle 870 after the start edge.
  - o_Tx_Active high for exactly 870 cycles.
- Pattern 0xA5: sampling mid-bit, the line reads 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop).
- Continuous i_Tx_DV=1 with data 0x99 then 0xAA changed mid-frame:
  - First frame carries 0x99 intact.
  - Second frame starts 2 idle cycles after the first o_Tx_Done and carries 0xAA.
- Busy rejection: pulse i_Tx_DV with 0x55 during the STOP of a 0x0F frame -> no extra frame is sent; only 0x0F appears.
- Parameter sweep: DATA_WIDTH=5, CLKS_PER_BIT=4, data 0x13 -> 7 bits of 4 cycles each (0,1,1,0,0,1,1); o_Tx_Done at cycle 28.
